// File: rtl/fp_mult_pipe.sv
// Pipelined sign/biased-exponent/hidden-one multiplier with valid/ready flow control.
// Define FP_MULT_ROUND_EN for round-half-up on the guard bit; otherwise discarded bits are truncated.
`timescale 1ns/1ps
module fp_mult_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 6
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] data_a,
  input  logic [EXP_W+MAN_W:0] data_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] data_x,
  output logic                 ovf,
  output logic                 unf
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam int HW = MAN_W + 3;
  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_MIN = EW'(1);

  logic                 advance;
  logic                 v0_q;
  logic [W-1:0]         a_q, b_q;
  logic                 s1_valid_q, s1_zero_q, s1_sign_q;
  logic signed [EW-1:0] s1_exp_q;
  logic [MAN_W:0]       s1_ma_q, s1_mb_q;
  logic                 s1_zero_d, s1_sign_d;
  logic signed [EW-1:0] s1_exp_d;
  logic                 s2_valid_q, s2_zero_q, s2_sign_q;
  logic signed [EW-1:0] s2_exp_q;
  logic [HW-1:0]        s2_prod_q;
  logic [PW-1:0]        prod_full;
  logic                 unused_prod_low;
  logic                 s3_valid_q, s3_zero_q, s3_sign_q;
  logic signed [EW-1:0] s3_exp_q, s3_exp_d;
  logic [MAN_W-1:0]     s3_man_q, s3_man_d;
  logic [MAN_W-1:0]     man_r;
  logic                 round_carry;
  logic signed [EW-1:0] exp_f;
  logic [W-1:0]         data_x_q, data_x_d;
  logic                 out_valid_q, ovf_q, unf_q, ovf_d, unf_d;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign data_x    = data_x_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

  // S1: zero detect, sign, biased exponent sum
  always_comb begin
    s1_zero_d = (a_q[W-2 -: EXP_W] == '0) || (b_q[W-2 -: EXP_W] == '0);
    s1_sign_d = a_q[W-1] ^ b_q[W-1];
    s1_exp_d  = $signed({2'b00, a_q[W-2 -: EXP_W]}) + $signed({2'b00, b_q[W-2 -: EXP_W]}) - BIAS;
  end

  // S2: only the top MAN_W+3 product bits matter (leading pair, mantissa, guard)
  assign prod_full       = PW'(s1_ma_q) * PW'(s1_mb_q);
  assign unused_prod_low = ^prod_full[MAN_W-2:0];

  // S3: normalise a product in [2,4) down to [1,2)
  always_comb begin
    if (s2_prod_q[HW-1]) begin
      s3_man_d = s2_prod_q[HW-2 -: MAN_W];
      s3_exp_d = s2_exp_q + EW'(1);
    end else begin
      s3_man_d = s2_prod_q[HW-3 -: MAN_W];
      s3_exp_d = s2_exp_q;
    end
  end

`ifdef FP_MULT_ROUND_EN
  logic s3_guard_q, s3_guard_d;
  assign s3_guard_d = s2_prod_q[HW-1] ? s2_prod_q[1] : s2_prod_q[0];
  always_ff @(posedge clk) begin
    if (advance) s3_guard_q <= s3_guard_d;
  end
  assign {round_carry, man_r} = {1'b0, s3_man_q} + (MAN_W + 1)'(s3_guard_q);
`else
  logic unused_guard;
  assign unused_guard = s2_prod_q[0];
  assign round_carry  = 1'b0;
  assign man_r        = s3_man_q;
`endif

  // S4: a rounding carry leaves man_r at zero and bumps the exponent before the range checks
  always_comb begin
    exp_f    = s3_exp_q + EW'(round_carry);
    data_x_d = '0;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (!s3_zero_q) begin
      if (exp_f < EXP_MIN) begin
        unf_d = 1'b1;
      end else if (exp_f > EXP_MAX) begin
        data_x_d = {s3_sign_q, {(W - 1){1'b1}}};
        ovf_d    = 1'b1;
      end else begin
        data_x_d = {s3_sign_q, exp_f[EXP_W-1:0], man_r};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v0_q        <= 1'b0;
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      data_x_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else if (advance) begin
      v0_q        <= in_valid;
      s1_valid_q  <= v0_q;
      s2_valid_q  <= s1_valid_q;
      s3_valid_q  <= s2_valid_q;
      out_valid_q <= s3_valid_q;
      if (s3_valid_q) begin
        data_x_q <= data_x_d;
        ovf_q    <= ovf_d;
        unf_q    <= unf_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      a_q       <= data_a;
      b_q       <= data_b;
      s1_zero_q <= s1_zero_d;
      s1_sign_q <= s1_sign_d;
      s1_exp_q  <= s1_exp_d;
      s1_ma_q   <= {1'b1, a_q[MAN_W-1:0]};
      s1_mb_q   <= {1'b1, b_q[MAN_W-1:0]};
      s2_zero_q <= s1_zero_q;
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s1_exp_q;
      s2_prod_q <= prod_full[PW-1:MAN_W-1];
      s3_zero_q <= s2_zero_q;
      s3_sign_q <= s2_sign_q;
      s3_exp_q  <= s3_exp_d;
      s3_man_q  <= s3_man_d;
    end
  end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe: directed vectors, backpressure, mid-stream reset and
// random sweeps at 5/6 and 8/7 formats against a real-number model.
`timescale 1ns/1ps
module tb_fp_mult_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready, ovf, unf;
  logic [11:0] data_a, data_b, data_x;
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_ovf, w_unf;
  logic [15:0] w_a, w_b, w_x;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FP_MULT_ROUND_EN
  localparam logic [11:0] RND_X = 12'h3CD;
`else
  localparam logic [11:0] RND_X = 12'h3CC;
`endif

  fp_mult_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .data_a(data_a), .data_b(data_b), .out_valid(out_valid), .out_ready(out_ready),
    .data_x(data_x), .ovf(ovf), .unf(unf)
  );

  fp_mult_pipe #(.EXP_W(8), .MAN_W(7)) dut_wide (
    .clk(clk), .reset_n(reset_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .data_a(w_a), .data_b(w_b), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .data_x(w_x), .ovf(w_ovf), .unf(w_unf)
  );

  // Real-valued reference: returns {ovf, unf, x[15:0]}
  function automatic logic [17:0] model(input int e_w, input int m_w, input logic [15:0] a,
                                        input logic [15:0] b);
    int  mmask = (1 << m_w) - 1;
    int  emask = (1 << e_w) - 1;
    int  bias  = (1 << (e_w - 1)) - 1;
    int  ea    = (int'(a) >> m_w) & emask;
    int  eb    = (int'(b) >> m_w) & emask;
    int  s     = ((int'(a) ^ int'(b)) >> (e_w + m_w)) & 1;
    int  e, mi;
    real p, frac;
    if (ea == 0 || eb == 0) return 18'h0;
    p = (1.0 + real'(int'(a) & mmask) / real'(1 << m_w)) *
        (1.0 + real'(int'(b) & mmask) / real'(1 << m_w));
    e = ea + eb - bias;
    if (p >= 2.0) begin
      p = p / 2.0;
      e = e + 1;
    end
    frac = (p - 1.0) * real'(1 << m_w);
`ifdef FP_MULT_ROUND_EN
    mi = int'($floor(frac + 0.5));
`else
    mi = int'($floor(frac));
`endif
    if (mi == (1 << m_w)) begin
      mi = 0;
      e  = e + 1;
    end
    if (e < 1) return {2'b01, 16'h0};
    if (e > emask) return {2'b10, 16'((s << (e_w + m_w)) | ((1 << (e_w + m_w)) - 1))};
    return {2'b00, 16'((s << (e_w + m_w)) | (e << m_w) | mi)};
  endfunction

  function automatic logic [15:0] rand_op(input int e_w, input int m_w);
    int bias = (1 << (e_w - 1)) - 1;
    int s    = int'($urandom_range(0, 1));
    int m    = int'($urandom_range(0, (1 << m_w) - 1));
    int e;
    if ($urandom_range(0, 3) == 0) e = int'($urandom_range(0, (1 << e_w) - 1));
    else e = int'($urandom_range(bias / 2, bias + bias / 2));
    return 16'((s << (e_w + m_w)) | (e << m_w) | m);
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; data_a = '0; data_b = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1; w_a = '0; w_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (data_x !== 12'h000) begin n_fail++; $display("FAIL reset_data_x: got %h expected 000", data_x); end
    n_checks++; if ({ovf, unf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got ovf=%b unf=%b expected 0 0", ovf, unf); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    $display("reset: out_valid=%b data_x=%h in_ready=%b", out_valid, data_x, in_ready);
  endtask

  task automatic test_latency();
    @(negedge clk); in_valid = 1'b1; data_a = 12'h3E0; data_b = 12'h3E0;
    @(negedge clk); in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early: edge n+%0d out_valid got %b expected 0", k, out_valid); end
      @(negedge clk);
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency_valid: edge n+4 out_valid got %b expected 1", out_valid); end
    n_checks++; if (data_x !== 12'h408) begin n_fail++; $display("FAIL latency_data: got %h expected 408", data_x); end
    $display("latency: 3E0*3E0 -> %h valid=%b", data_x, out_valid);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_dup: out_valid got %b expected 0", out_valid); end
  endtask

  task automatic test_directed();
    logic [11:0] va [7];
    logic [11:0] vb [7];
    logic [11:0] vx [7];
    logic [1:0]  vf [7];
    int k = 0;
    va = '{12'h3E0, 12'h400, 12'hBC0, 12'h000, 12'h7FF, 12'h040, 12'h3C6};
    vb = '{12'h3E0, 12'h400, 12'h3E0, 12'h7FF, 12'h7FF, 12'h040, 12'h3C6};
    vx = '{12'h408, 12'h440, 12'hBE0, 12'h000, 12'h7FF, 12'h000, RND_X};
    vf = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};
    for (int cyc = 0; cyc < 40 && k < 7; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (data_x !== vx[k] || {ovf, unf} !== vf[k]) begin
          n_fail++;
          $display("FAIL directed_%0d: %h*%h got x=%h ovf=%b unf=%b expected x=%h ovf=%b unf=%b",
                   k, va[k], vb[k], data_x, ovf, unf, vx[k], vf[k][1], vf[k][0]);
        end
        $display("directed: %h*%h -> x=%h ovf=%b unf=%b", va[k], vb[k], data_x, ovf, unf);
        k++;
      end
      if (cyc < 7) begin in_valid = 1'b1; data_a = va[cyc]; data_b = vb[cyc]; end
      else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    n_checks++; if (k !== 7) begin n_fail++; $display("FAIL directed_count: got %0d results expected 7", k); end
  endtask

  task automatic test_backpressure();
    logic [17:0] expq [$];
    logic [11:0] pa [20];
    logic [11:0] pb [20];
    logic [17:0] e;
    logic        acc_in, acc_out;
    int sent = 0, got = 0;
    for (int i = 0; i < 20; i++) begin pa[i] = 12'(rand_op(5, 6)); pb[i] = 12'(rand_op(5, 6)); end
    for (int cyc = 0; cyc < 500 && got < 20; cyc++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 20) begin in_valid = 1'b1; data_a = pa[sent]; data_b = pb[sent]; end
      else in_valid = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_fail++;
        $display("FAIL bp_in_ready: got %b expected %b (out_valid=%b out_ready=%b)",
                 in_ready, !(out_valid && !out_ready), out_valid, out_ready);
      end
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: got x=%h with no item outstanding, expected none", data_x);
        end else begin
          e = expq.pop_front();
          if ({ovf, unf, data_x} !== {e[17:16], e[11:0]}) begin
            n_fail++;
            $display("FAIL bp_data_%0d: got x=%h ovf=%b unf=%b expected x=%h ovf=%b unf=%b",
                     got, data_x, ovf, unf, e[11:0], e[17], e[16]);
          end
        end
        $display("backpressure: result %0d x=%h ovf=%b unf=%b", got, data_x, ovf, unf);
        got++;
      end
      if (acc_in) begin
        expq.push_back(model(5, 6, {4'h0, pa[sent]}, {4'h0, pb[sent]}));
        sent++;
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (got !== 20 || sent !== 20) begin n_fail++; $display("FAIL bp_count: got %0d sent %0d expected 20 20", got, sent); end
    n_checks++; if (expq.size() !== 0) begin n_fail++; $display("FAIL bp_leftover: got %0d outstanding expected 0", expq.size()); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk); out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; data_a = 12'h3E0; data_b = 12'h3E0;
      @(negedge clk);
    end
    in_valid = 1'b0; reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    for (int k = 0; k < 6; k++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_flush: cycle %0d out_valid got %b expected 0", k, out_valid); end
      @(negedge clk);
    end
    in_valid = 1'b1; data_a = 12'h400; data_b = 12'h400;
    @(negedge clk); in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_early: edge n+%0d out_valid got %b expected 0", k, out_valid); end
      @(negedge clk);
    end
    n_checks++;
    if (out_valid !== 1'b1 || data_x !== 12'h440) begin
      n_fail++;
      $display("FAIL rstmid_result: got valid=%b x=%h expected valid=1 x=440", out_valid, data_x);
    end
    $display("reset midstream: 400*400 -> %h valid=%b", data_x, out_valid);
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [17:0] expq [$];
    logic [11:0] qa [$];
    logic [11:0] qb [$];
    logic [17:0] e;
    logic [11:0] a, b, ea, eb;
    int sent = 0, got = 0;
    for (int cyc = 0; cyc < 250 && got < 150; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL sweep_extra: got x=%h expected no result", data_x);
        end else begin
          e = expq.pop_front(); ea = qa.pop_front(); eb = qb.pop_front();
          if ({ovf, unf, data_x} !== {e[17:16], e[11:0]}) begin
            n_fail++;
            $display("FAIL sweep_%0d: %h*%h got x=%h ovf=%b unf=%b expected x=%h ovf=%b unf=%b",
                     got, ea, eb, data_x, ovf, unf, e[11:0], e[17], e[16]);
          end
          $display("sweep: %h*%h -> x=%h ovf=%b unf=%b", ea, eb, data_x, ovf, unf);
        end
        got++;
      end
      if (sent < 150) begin
        a = 12'(rand_op(5, 6)); b = 12'(rand_op(5, 6));
        in_valid = 1'b1; data_a = a; data_b = b;
        expq.push_back(model(5, 6, {4'h0, a}, {4'h0, b})); qa.push_back(a); qb.push_back(b);
        sent++;
      end else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    n_checks++; if (got !== 150) begin n_fail++; $display("FAIL sweep_count: got %0d expected 150", got); end
  endtask

  task automatic test_sweep_wide();
    logic [17:0] expq [$];
    logic [15:0] qa [$];
    logic [15:0] qb [$];
    logic [17:0] e;
    logic [15:0] a, b, ea, eb;
    int sent = 0, got = 0;
    for (int cyc = 0; cyc < 200 && got < 100; cyc++) begin
      @(negedge clk);
      if (w_out_valid) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL wide_extra: got x=%h expected no result", w_x);
        end else begin
          e = expq.pop_front(); ea = qa.pop_front(); eb = qb.pop_front();
          if ({w_ovf, w_unf, w_x} !== e) begin
            n_fail++;
            $display("FAIL wide_%0d: %h*%h got x=%h ovf=%b unf=%b expected x=%h ovf=%b unf=%b",
                     got, ea, eb, w_x, w_ovf, w_unf, e[15:0], e[17], e[16]);
          end
          $display("wide: %h*%h -> x=%h ovf=%b unf=%b", ea, eb, w_x, w_ovf, w_unf);
        end
        got++;
      end
      if (sent < 100) begin
        a = rand_op(8, 7); b = rand_op(8, 7);
        w_in_valid = 1'b1; w_a = a; w_b = b;
        expq.push_back(model(8, 7, a, b)); qa.push_back(a); qb.push_back(b);
        sent++;
      end else w_in_valid = 1'b0;
    end
    w_in_valid = 1'b0;
    n_checks++; if (got !== 100) begin n_fail++; $display("FAIL wide_count: got %0d expected 100", got); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    test_sweep();
    test_sweep_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
